// File: rtl/core_mem_bus.sv
// Sequential load/store bus master: one req/ack transaction at a time, aligned/extended load return.
// Optional access timeout enabled by defining CORE_MEM_BUS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module core_mem_bus #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_mem_sel,
    output logic        o_resp_valid,
    output logic        o_resp_err,
    output logic [31:0] o_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_sel,
    input  logic        i_bus_ack,
    input  logic        i_bus_err,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        accept;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

`ifdef CORE_MEM_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    assign o_req_ready = (state == IDLE) || (state == RESP);
    assign accept      = i_req_valid && o_req_ready;

    // Halfword lane uses offset bit 1 only; bit 0 is deliberately ignored.
    always_comb begin
        load_byte = i_bus_rdata[7:0];
        case (offset_q)
            2'd0: load_byte = i_bus_rdata[7:0];
            2'd1: load_byte = i_bus_rdata[15:8];
            2'd2: load_byte = i_bus_rdata[23:16];
            2'd3: load_byte = i_bus_rdata[31:24];
            default: load_byte = i_bus_rdata[7:0];
        endcase
        load_half = offset_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'h000000, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'h0000, load_half};
            default: load_data = i_bus_rdata;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            funct3_q     <= '0;
            offset_q     <= '0;
            o_bus_req    <= 1'b0;
            o_bus_we     <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_wdata  <= '0;
            o_bus_sel    <= '0;
            o_resp_valid <= 1'b0;
            o_resp_err   <= 1'b0;
            o_rdata      <= '0;
`ifdef CORE_MEM_BUS_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
        end else begin
            o_resp_valid <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        funct3_q    <= i_funct3;
                        offset_q    <= i_addr[1:0];
                        o_bus_we    <= i_req_we;
                        o_bus_addr  <= {i_addr[31:2], 2'b00};
                        o_bus_wdata <= i_wdata;
                        o_bus_sel   <= i_req_we ? i_mem_sel : 4'b1111;
                        o_bus_req   <= 1'b1;
                        state       <= BUS;
`ifdef CORE_MEM_BUS_TIMEOUT_EN
                        wait_cnt    <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                BUS: begin
                    if (i_bus_err) begin
                        o_rdata      <= '0;
                        o_resp_err   <= 1'b1;
                        o_resp_valid <= 1'b1;
                        o_bus_req    <= 1'b0;
                        state        <= RESP;
                    end else if (i_bus_ack) begin
                        o_rdata      <= o_bus_we ? '0 : load_data;
                        o_resp_err   <= 1'b0;
                        o_resp_valid <= 1'b1;
                        o_bus_req    <= 1'b0;
                        state        <= RESP;
                    end
`ifdef CORE_MEM_BUS_TIMEOUT_EN
                    // Ack/err take precedence over an expiring counter in the same cycle.
                    else if (wait_cnt == CNT_LAST) begin
                        o_rdata      <= '0;
                        o_resp_err   <= 1'b1;
                        o_resp_valid <= 1'b1;
                        o_bus_req    <= 1'b0;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    o_bus_req <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_bus.sv
// Directed self-checking bench for core_mem_bus; timeout steps follow CORE_MEM_BUS_TIMEOUT_EN.
module tb_core_mem_bus;

`ifdef CORE_MEM_BUS_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_mem_sel;
    logic        o_resp_valid;
    logic        o_resp_err;
    logic [31:0] o_rdata;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_sel;
    logic        i_bus_ack;
    logic        i_bus_err;
    logic [31:0] i_bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    core_mem_bus #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_mem_sel    (i_mem_sel),
        .o_resp_valid (o_resp_valid),
        .o_resp_err   (o_resp_err),
        .o_rdata      (o_rdata),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_sel    (o_bus_sel),
        .i_bus_ack    (i_bus_ack),
        .i_bus_err    (i_bus_err),
        .i_bus_rdata  (i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue a load at a negedge, ack after ack_dly cycles, then check the response and its hold.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rd, input int ack_dly, input logic [31:0] exp);
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_funct3    = f3;
        i_addr      = a;
        i_wdata     = 32'hDEADBEEF;
        i_mem_sel   = 4'b0001;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check({tag, "_bus_req"}, 32'(o_bus_req), 32'd1);
        check({tag, "_bus_addr"}, o_bus_addr, {a[31:2], 2'b00});
        check({tag, "_bus_sel"}, 32'(o_bus_sel), 32'hF);
        check({tag, "_ready_busy"}, 32'(o_req_ready), 32'd0);
        repeat (ack_dly - 1) @(negedge i_clk);
        check({tag, "_no_early_resp"}, 32'(o_resp_valid), 32'd0);
        i_bus_ack   = 1'b1;
        i_bus_rdata = rd;
        @(negedge i_clk);
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'h0;
        check({tag, "_resp_valid"}, 32'(o_resp_valid), 32'd1);
        check({tag, "_resp_err"}, 32'(o_resp_err), 32'd0);
        check({tag, "_rdata"}, o_rdata, exp);
        check({tag, "_bus_req_drop"}, 32'(o_bus_req), 32'd0);
        @(negedge i_clk);
        check({tag, "_resp_pulse"}, 32'(o_resp_valid), 32'd0);
        check({tag, "_rdata_hold"}, o_rdata, exp);
    endtask

    initial begin
        int cnt;
        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_we    = 1'b0;
        i_funct3    = 3'b000;
        i_addr      = 32'h0;
        i_wdata     = 32'h0;
        i_mem_sel   = 4'b0000;
        i_bus_ack   = 1'b0;
        i_bus_err   = 1'b0;
        i_bus_rdata = 32'h0;

        repeat (2) @(negedge i_clk);
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_bus_req", 32'(o_bus_req), 32'd0);
        check("rst_bus_we", 32'(o_bus_we), 32'd0);
        check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
        check("rst_resp_err", 32'(o_resp_err), 32'd0);
        check("rst_bus_addr", o_bus_addr, 32'h0);
        check("rst_bus_wdata", o_bus_wdata, 32'h0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_bus_sel", 32'(o_bus_sel), 32'h0);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Stray ack/err while idle must be ignored.
        i_bus_ack = 1'b1;
        i_bus_err = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        i_bus_err = 1'b0;
        check("idle_ack_resp", 32'(o_resp_valid), 32'd0);
        check("idle_ack_req", 32'(o_bus_req), 32'd0);

        do_load("lb_b3",   3'b000, 32'h0000_1003, 32'h80FF1234, 3, 32'hFFFFFF80);
        do_load("lhu_h1",  3'b101, 32'h0000_2002, 32'hBEEF0000, 1, 32'h0000BEEF);
        do_load("lh_h1",   3'b001, 32'h0000_2002, 32'hBEEF0000, 2, 32'hFFFFBEEF);
        do_load("lbu_b1",  3'b100, 32'h0000_1001, 32'h80FF1234, 1, 32'h00000012);
        do_load("lb_b2",   3'b000, 32'h0000_1002, 32'h80FF1234, 1, 32'hFFFFFFFF);
        do_load("lh_a0",   3'b001, 32'h0000_2001, 32'h00008001, 1, 32'hFFFF8001);
        do_load("lw",      3'b010, 32'h0000_7000, 32'h13579BDF, 1, 32'h13579BDF);
        do_load("f3_odd",  3'b011, 32'h0000_7003, 32'hA5A50F0F, 1, 32'hA5A50F0F);

        // SB store
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_funct3    = 3'b000;
        i_addr      = 32'h0000_3001;
        i_wdata     = 32'h5A5A5A5A;
        i_mem_sel   = 4'b0010;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("sb_bus_req", 32'(o_bus_req), 32'd1);
        check("sb_bus_we", 32'(o_bus_we), 32'd1);
        check("sb_bus_sel", 32'(o_bus_sel), 32'h2);
        check("sb_bus_wdata", o_bus_wdata, 32'h5A5A5A5A);
        check("sb_bus_addr", o_bus_addr, 32'h0000_3000);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'hFFFFFFFF;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        check("sb_resp_valid", 32'(o_resp_valid), 32'd1);
        check("sb_rdata", o_rdata, 32'h0);
        check("sb_resp_err", 32'(o_resp_err), 32'd0);
        @(negedge i_clk);

        // LW with err and ack together, then back-to-back SW in the RESP cycle
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_funct3    = 3'b010;
        i_addr      = 32'h0000_4000;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_bus_ack   = 1'b1;
        i_bus_err   = 1'b1;
        i_bus_rdata = 32'h12345678;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        i_bus_err = 1'b0;
        check("err_resp_valid", 32'(o_resp_valid), 32'd1);
        check("err_resp_err", 32'(o_resp_err), 32'd1);
        check("err_rdata", o_rdata, 32'h0);
        check("err_ready", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_funct3    = 3'b010;
        i_addr      = 32'h0000_5004;
        i_wdata     = 32'hCAFEBABE;
        i_mem_sel   = 4'b1111;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("b2b_bus_req", 32'(o_bus_req), 32'd1);
        check("b2b_bus_addr", o_bus_addr, 32'h0000_5004);
        check("b2b_bus_wdata", o_bus_wdata, 32'hCAFEBABE);
        check("b2b_bus_we", 32'(o_bus_we), 32'd1);
        check("b2b_no_resp", 32'(o_resp_valid), 32'd0);
        check("b2b_err_hold", 32'(o_resp_err), 32'd1);
        i_bus_ack = 1'b1;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        check("sw_resp_valid", 32'(o_resp_valid), 32'd1);
        check("sw_resp_err", 32'(o_resp_err), 32'd0);
        @(negedge i_clk);

        // Asynchronous reset while waiting on the bus
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_funct3    = 3'b010;
        i_addr      = 32'h0000_6000;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        check("rstmid_req_before", 32'(o_bus_req), 32'd1);
        #2 i_reset = 1'b1;
        #1;
        check("rstmid_req_async", 32'(o_bus_req), 32'd0);
        check("rstmid_no_resp", 32'(o_resp_valid), 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        check("rstmid_ready", 32'(o_req_ready), 32'd1);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h55555555;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        check("late_ack_resp", 32'(o_resp_valid), 32'd0);
        check("late_ack_req", 32'(o_bus_req), 32'd0);
        check("late_ack_rdata", o_rdata, 32'h0);

        // Access with no ack
        i_req_valid = 1'b1;
        i_req_we    = 1'b0;
        i_funct3    = 3'b010;
        i_addr      = 32'h0000_8000;
        @(negedge i_clk);
        i_req_valid = 1'b0;
`ifdef CORE_MEM_BUS_TIMEOUT_EN
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!o_bus_req) break;
            cnt++;
            @(negedge i_clk);
        end
        check("to_req_cycles", 32'(cnt), 32'd4);
        check("to_resp_valid", 32'(o_resp_valid), 32'd1);
        check("to_resp_err", 32'(o_resp_err), 32'd1);
        check("to_rdata", o_rdata, 32'h0);
        @(negedge i_clk);
        // Ack on the expiring cycle wins over the timeout.
        i_req_valid = 1'b1;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h11223344;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        check("to_ack_wins_valid", 32'(o_resp_valid), 32'd1);
        check("to_ack_wins_err", 32'(o_resp_err), 32'd0);
        check("to_ack_wins_rdata", o_rdata, 32'h11223344);
`else
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (o_bus_req && !o_resp_valid) cnt++;
            @(negedge i_clk);
        end
        check("noto_req_held", 32'(cnt), 32'd300);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h0BADF00D;
        @(negedge i_clk);
        i_bus_ack = 1'b0;
        check("noto_resp_valid", 32'(o_resp_valid), 32'd1);
        check("noto_rdata", o_rdata, 32'h0BADF00D);
`endif
        @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
